// File: rtl/sim_stall_ctrl.sv
// Stall arbiter between the simulation DPI shims and the VTA core: drains
// in-flight work, holds the stall while any requester wants it, and enforces a hold-off.
module sim_stall_ctrl #(
    parameter int NUM_REQ     = 2,
    parameter int DRAIN_MAX   = 16,
    parameter int RESUME_HOLD = 2,
    parameter int CNT_W       = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic [NUM_REQ-1:0] req,
    input  logic               core_idle,
    output logic               drain_req,
    output logic               stall,
    output logic [NUM_REQ-1:0] ack,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic [CNT_W-1:0]   stall_events,
    output logic               drain_timeout
);

    localparam int DRAIN_W = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
    localparam int HOLD_W  = (RESUME_HOLD > 1) ? $clog2(RESUME_HOLD) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_MAX - 1);
    localparam logic [HOLD_W-1:0]  HOLD_INIT  = HOLD_W'(RESUME_HOLD - 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_STALL,
        S_RESUME
    } state_t;

    state_t               state_q;
    logic [DRAIN_W-1:0]   drain_cnt_q;
    logic [HOLD_W-1:0]    hold_cnt_q;
    logic                 drain_req_q;
    logic                 stall_q;
    logic [NUM_REQ-1:0]   ack_q;
    logic [CNT_W-1:0]     cycles_q, cycles_d;
    logic [CNT_W-1:0]     events_q, events_d;
    logic                 timeout_q, timeout_d;
    logic                 any_req;
    logic                 drain_done;
    logic                 drain_to;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign any_req = |req;
    // Abort (no requester left) wins over both drain exits; idle wins over timeout.
    assign drain_done = (state_q == S_DRAIN) && any_req &&
                        (core_idle || (drain_cnt_q == DRAIN_LAST));
    assign drain_to   = (state_q == S_DRAIN) && any_req && !core_idle &&
                        (drain_cnt_q == DRAIN_LAST);

    always_comb begin
        cycles_d  = cycles_q;
        events_d  = events_q;
        timeout_d = timeout_q;
        if (clear) begin
            cycles_d  = '0;
            events_d  = '0;
            timeout_d = 1'b0;
        end else begin
            if (state_q == S_STALL) cycles_d = sat_inc(cycles_q);
            if (drain_done)         events_d = sat_inc(events_q);
            if (drain_to)           timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_RUN;
            drain_cnt_q <= '0;
            hold_cnt_q  <= '0;
            drain_req_q <= 1'b0;
            stall_q     <= 1'b0;
            ack_q       <= '0;
            cycles_q    <= '0;
            events_q    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            cycles_q  <= cycles_d;
            events_q  <= events_d;
            timeout_q <= timeout_d;
            case (state_q)
                S_RUN: begin
                    if (any_req) begin
                        state_q     <= S_DRAIN;
                        drain_cnt_q <= '0;
                        drain_req_q <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (!any_req) begin
                        state_q     <= S_RUN;
                        drain_req_q <= 1'b0;
                    end else if (drain_done) begin
                        state_q <= S_STALL;
                        stall_q <= 1'b1;
                        ack_q   <= req;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 1'b1;
                    end
                end
                S_STALL: begin
                    if (!any_req) begin
                        state_q     <= S_RESUME;
                        hold_cnt_q  <= HOLD_INIT;
                        drain_req_q <= 1'b0;
                        stall_q     <= 1'b0;
                        ack_q       <= '0;
                    end else begin
                        ack_q <= req;
                    end
                end
                S_RESUME: begin
                    // Requests are deliberately ignored here so the core gets cycles.
                    if (hold_cnt_q == '0) state_q <= S_RUN;
                    else                  hold_cnt_q <= hold_cnt_q - 1'b1;
                end
                default: state_q <= S_RUN;
            endcase
        end
    end

    assign drain_req     = drain_req_q;
    assign stall         = stall_q;
    assign ack           = ack_q;
    assign stall_cycles  = cycles_q;
    assign stall_events  = events_q;
    assign drain_timeout = timeout_q;

endmodule

// File: tb/tb_sim_stall_ctrl.sv
// Bench for sim_stall_ctrl: directed scenarios plus randomized traffic checked
// against a cycle-stamp reference model.
module tb_sim_stall_ctrl;

    localparam int NUM_REQ     = 2;
    localparam int DRAIN_MAX   = 16;
    localparam int RESUME_HOLD = 2;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;
    localparam int VW          = 2 * CNT_W + 5;

    localparam int M_RUN    = 0;
    localparam int M_DRAIN  = 1;
    localparam int M_STALL  = 2;
    localparam int M_RESUME = 3;

    logic               clock = 1'b0;
    logic               reset;
    logic               clear;
    logic [NUM_REQ-1:0] req;
    logic               core_idle;
    logic               drain_req;
    logic               stall;
    logic [NUM_REQ-1:0] ack;
    logic [CNT_W-1:0]   stall_cycles;
    logic [CNT_W-1:0]   stall_events;
    logic               drain_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: phase plus the cycle stamps of drain entry and release.
    int         m_phase = M_RUN;
    int         m_now = 0;
    int         m_drain_start = 0;
    int         m_release = 0;
    int         m_cyc = 0;
    int         m_evt = 0;
    bit         m_to = 1'b0;
    logic [1:0] m_ack = 2'b00;

    sim_stall_ctrl #(
        .NUM_REQ    (NUM_REQ),
        .DRAIN_MAX  (DRAIN_MAX),
        .RESUME_HOLD(RESUME_HOLD),
        .CNT_W      (CNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .clear        (clear),
        .req          (req),
        .core_idle    (core_idle),
        .drain_req    (drain_req),
        .stall        (stall),
        .ack          (ack),
        .stall_cycles (stall_cycles),
        .stall_events (stall_events),
        .drain_timeout(drain_timeout)
    );

    always #5 clock = ~clock;

    task automatic model_edge();
        int  nxt;
        bit  entered;
        bit  timed_out;
        m_now++;
        if (reset) begin
            m_phase = M_RUN;
            m_cyc = 0;
            m_evt = 0;
            m_to = 1'b0;
            m_ack = 2'b00;
            return;
        end
        nxt = m_phase;
        entered = 1'b0;
        timed_out = 1'b0;
        if (m_phase == M_RUN && req != 0) begin
            nxt = M_DRAIN;
            m_drain_start = m_now;
        end else if (m_phase == M_DRAIN) begin
            if (req == 0) nxt = M_RUN;
            else if (core_idle) begin
                nxt = M_STALL;
                entered = 1'b1;
            end else if (m_now - m_drain_start == DRAIN_MAX) begin
                nxt = M_STALL;
                entered = 1'b1;
                timed_out = 1'b1;
            end
        end else if (m_phase == M_STALL && req == 0) begin
            nxt = M_RESUME;
            m_release = m_now;
        end else if (m_phase == M_RESUME && m_now - m_release == RESUME_HOLD) begin
            nxt = M_RUN;
        end
        if (clear) begin
            m_cyc = 0;
            m_evt = 0;
            m_to = 1'b0;
        end else begin
            if (m_phase == M_STALL) m_cyc = (m_cyc + 1 > CNT_MAX) ? CNT_MAX : m_cyc + 1;
            if (entered)            m_evt = (m_evt + 1 > CNT_MAX) ? CNT_MAX : m_evt + 1;
            if (timed_out)          m_to = 1'b1;
        end
        m_phase = nxt;
        m_ack = (nxt == M_STALL) ? req : 2'b00;
    endtask

    function automatic logic [VW-1:0] exp_vec();
        return {(m_phase == M_DRAIN || m_phase == M_STALL), (m_phase == M_STALL), m_ack,
                CNT_W'(m_cyc), CNT_W'(m_evt), m_to};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {drain_req, stall, ack, stall_cycles, stall_events, drain_timeout};
    endfunction

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear = 1'b0;
        req = 2'b00;
        core_idle = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear = 1'b0;
        req = 2'($urandom_range(1, 3));
        core_idle = 1'($urandom_range(0, 1));
        step();
        step();
        n_checks++;
        if (dut_vec() !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %0h expected 0", dut_vec());
        end
        reset = 1'b0;
        req = 2'b00;
        step();
        n_checks++;
        if (dut_vec() !== '0) begin
            n_fail++;
            $display("FAIL reset_idle_run: got %0h expected 0", dut_vec());
        end
    endtask

    task automatic test_basic_stall();
        do_reset();
        core_idle = 1'b1;
        req = 2'b01;
        step();
        n_checks++;
        if ({drain_req, stall, ack} !== 4'b1000) begin
            n_fail++;
            $display("FAIL basic_drain: got %b expected 1000", {drain_req, stall, ack});
        end
        step();
        n_checks++;
        if ({drain_req, stall, ack} !== 4'b1101) begin
            n_fail++;
            $display("FAIL basic_stall_entry: got %b expected 1101", {drain_req, stall, ack});
        end
        repeat (4) begin
            step();
            n_checks++;
            if ({drain_req, stall, ack} !== 4'b1101) begin
                n_fail++;
                $display("FAIL basic_stall_hold: got %b expected 1101", {drain_req, stall, ack});
            end
        end
        req = 2'b00;
        step();
        n_checks++;
        if ({drain_req, stall, ack, stall_cycles, stall_events} !== {4'b0000, 4'd5, 4'd1}) begin
            n_fail++;
            $display("FAIL basic_release: got %h expected 051",
                     {drain_req, stall, ack, stall_cycles, stall_events});
        end
        step();
        n_checks++;
        if ({drain_req, stall} !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_resume: got %b expected 00", {drain_req, stall});
        end
    endtask

    task automatic test_drain_timeout();
        int drain_len;
        do_reset();
        core_idle = 1'b0;
        req = 2'b10;
        drain_len = 0;
        for (int i = 0; i < 40 && !stall; i++) begin
            step();
            if (!stall && drain_req) drain_len++;
        end
        n_checks++;
        if (drain_len != DRAIN_MAX || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_length: got %0d cycles stall=%b expected 16 stall=1",
                     drain_len, stall);
        end
        n_checks++;
        if ({drain_timeout, stall_events, ack} !== {1'b1, 4'd1, 2'b10}) begin
            n_fail++;
            $display("FAIL timeout_flag: got to=%b ev=%0d ack=%b expected to=1 ev=1 ack=10",
                     drain_timeout, stall_events, ack);
        end
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        n_checks++;
        if ({drain_timeout, stall_cycles, stall_events, stall} !== {1'b0, 4'd0, 4'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL timeout_clear: got to=%b cyc=%0d ev=%0d stall=%b expected 0 0 0 1",
                     drain_timeout, stall_cycles, stall_events, stall);
        end
        req = 2'b00;
        repeat (4) step();
    endtask

    task automatic test_abort();
        do_reset();
        core_idle = 1'b0;
        req = 2'b01;
        step();
        n_checks++;
        if ({drain_req, stall} !== 2'b10) begin
            n_fail++;
            $display("FAIL abort_drain: got %b expected 10", {drain_req, stall});
        end
        req = 2'b00;
        repeat (5) begin
            step();
            n_checks++;
            if ({drain_req, stall, ack} !== 4'b0000) begin
                n_fail++;
                $display("FAIL abort_quiet: got %b expected 0000", {drain_req, stall, ack});
            end
        end
        n_checks++;
        if ({stall_events, drain_timeout} !== 5'd0) begin
            n_fail++;
            $display("FAIL abort_stats: got ev=%0d to=%b expected 0 0", stall_events, drain_timeout);
        end
    endtask

    task automatic test_overlap();
        logic [1:0] exp_ack;
        logic       exp_stall;
        do_reset();
        core_idle = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            req = {(i >= 4 && i <= 8), (i <= 5)};
            step();
            exp_stall = (i >= 1 && i <= 8);
            exp_ack = exp_stall ? req : 2'b00;
            n_checks++;
            if ({stall, ack} !== {exp_stall, exp_ack}) begin
                n_fail++;
                $display("FAIL overlap_step%0d: got stall=%b ack=%b expected stall=%b ack=%b",
                         i, stall, ack, exp_stall, exp_ack);
            end
        end
        n_checks++;
        if (stall_events !== 4'd1) begin
            n_fail++;
            $display("FAIL overlap_events: got %0d expected 1", stall_events);
        end
    endtask

    task automatic test_holdoff();
        do_reset();
        core_idle = 1'b1;
        req = 2'b01;
        step();
        step();
        step();
        req = 2'b00;
        step();
        req = 2'b01;
        step();
        n_checks++;
        if ({drain_req, stall} !== 2'b00) begin
            n_fail++;
            $display("FAIL holdoff_resume: got %b expected 00", {drain_req, stall});
        end
        step();
        n_checks++;
        if ({drain_req, stall} !== 2'b00) begin
            n_fail++;
            $display("FAIL holdoff_run_entry: got %b expected 00", {drain_req, stall});
        end
        step();
        n_checks++;
        if ({drain_req, stall} !== 2'b10) begin
            n_fail++;
            $display("FAIL holdoff_redrain: got %b expected 10", {drain_req, stall});
        end
        step();
        n_checks++;
        if ({drain_req, stall, ack} !== 4'b1101) begin
            n_fail++;
            $display("FAIL holdoff_restall: got %b expected 1101", {drain_req, stall, ack});
        end
    endtask

    task automatic test_saturation();
        do_reset();
        core_idle = 1'b1;
        req = 2'b11;
        step();
        step();
        repeat (20) step();
        n_checks++;
        if ({stall, stall_cycles} !== {1'b1, 4'd15}) begin
            n_fail++;
            $display("FAIL saturation: got stall=%b cyc=%0d expected stall=1 cyc=15",
                     stall, stall_cycles);
        end
        req = 2'b00;
        repeat (4) step();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        core_idle = 1'b1;
        req = 2'b01;
        repeat (3) step();
        reset = 1'b1;
        step();
        n_checks++;
        if (dut_vec() !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %0h expected 0", dut_vec());
        end
        reset = 1'b0;
        step();
        n_checks++;
        if ({drain_req, stall} !== 2'b10) begin
            n_fail++;
            $display("FAIL midreset_redrain: got %b expected 10", {drain_req, stall});
        end
        req = 2'b00;
        repeat (4) step();
    endtask

    task automatic test_random();
        int   bit_idx;
        logic prev_dr;
        do_reset();
        prev_dr = drain_req;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                bit_idx = int'($urandom_range(0, NUM_REQ - 1));
                req[bit_idx] = ~req[bit_idx];
            end
            core_idle = (i < 750) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 31) == 0);
            clear = ($urandom_range(0, 63) == 0);
            reset = ($urandom_range(0, 299) == 0);
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %0h expected %0h", i, dut_vec(), exp_vec());
            end
            n_checks++;
            if ((ack != 0 && !stall) || (stall && !prev_dr && !reset)) begin
                n_fail++;
                $display("FAIL random_invariant%0d: got stall=%b ack=%b prev_drain=%b expected consistent",
                         i, stall, ack, prev_dr);
            end
            prev_dr = drain_req;
        end
        reset = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        req = 2'b00;
        core_idle = 1'b0;
        test_reset();
        test_basic_stall();
        test_drain_timeout();
        test_abort();
        test_overlap();
        test_holdoff();
        test_saturation();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sim_stall_ctrl.md
# sim_stall_ctrl

Arbitrates simulation-stall requests from several simulation-side sources, such as the DPI wait source and host/memory DPI agents, into one stall for the VTA core. Before stalling, it drains in-flight core activity. It then holds the stall while any requester needs it, and enforces a hold-off after release so the core always makes forward progress. It sits between the DPI shim modules and the core's clock-enable/stall input, and exposes stall statistics for the simulation driver.

## Interface
- NUM_REQ, 2, number of stall requesters (1..8)
- DRAIN_MAX, 16, maximum cycles spent in DRAIN before a forced stall (≥1)
- RESUME_HOLD, 2, cycles stall stays low after release before a new request is accepted (≥1)
- CNT_W, 32, width of the statistics counters

- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clock
- clear  in  1  synchronous clear of stall_cycles, stall_events, drain_timeout
- req  in  NUM_REQ  level stall request per requester
- core_idle  in  1  core has no in-flight transactions
- drain_req  out  1  asks the core to stop issuing new work
- stall  out  1  core stall/clock-enable-low
- ack  out  NUM_REQ  per-requester confirmation that stall is in effect
- stall_cycles  out  CNT_W  cycles spent in STALL, saturating
- stall_events  out  CNT_W  number of DRAIN→STALL entries, saturating
- drain_timeout  out  1  sticky: a drain ended by DRAIN_MAX, not core_idle

## Operation
- States are RUN, DRAIN, STALL and RESUME. All outputs are registered.
- RUN: drain_req=0, stall=0, ack=0. If |req → DRAIN, and the drain counter is cleared.
- DRAIN: drain_req=1, stall=0, ack=0. The drain counter increments each cycle.
  - If req==0 → RUN (abort). No event is counted.
  - Else if core_idle=1 → STALL.
  - Else if the drain counter reaches DRAIN_MAX-1 → STALL and drain_timeout is set.
  - Abort has priority over both exits.
- STALL: stall=1, drain_req=1, ack = req registered each cycle.
  - A requester joining mid-stall is acked on the next cycle; one leaving is un-acked on the next cycle.
  - stall_cycles increments every cycle in STALL.
  - If req==0 → RESUME, with the hold counter loaded to RESUME_HOLD-1.
- RESUME: all outputs 0. req is ignored. The hold counter decrements; at 0 → RUN.
- stall_events increments on the DRAIN→STALL transition.
- Both counters saturate at all-ones and never wrap.
- clear has priority over a same-cycle increment or drain_timeout set: the result is 0.
- reset at any point: state RUN, and every output is 0 (drain_req, stall, ack, stall_cycles, stall_events, drain_timeout) after the edge. The drain and hold counters are also cleared.

## Timing
- A req rising edge sampled at edge t gives drain_req=1 after edge t.
- If core_idle=1 at edge t+1, stall=1 and ack=1 after edge t+1. Minimum req→stall latency is 2 cycles.
- Worst-case req→stall latency is DRAIN_MAX+1 cycles (timeout path).
- If the last req drops at edge k, stall=0, ack=0 and drain_req=0 after edge k.
- A request present during RESUME is honoured on the first RUN cycle. RUN re-entry happens RESUME_HOLD cycles after release.
- ack is never 1 while stall is 0.
- stall is never 1 unless drain_req was 1 on the preceding cycle.

## Test plan
- Basic stall: core_idle=1, req=2'b01 for 5 cycles.
  - drain_req at +1, stall and ack=01 at +2, held 5 cycles.
  - After release, stall=0 for RESUME_HOLD=2 cycles.
  - stall_cycles=5, stall_events=1.
- Drain timeout: core_idle=0, req=2'b10 held.
  - DRAIN lasts exactly 16 cycles, then stall=1, drain_timeout=1.
  - clear pulse → drain_timeout=0, counters=0, stall still 1.
- Abort: req=01 for 1 cycle with core_idle=0.
  - drain_req pulses for 1 cycle, never stall.
  - stall_events=0, drain_timeout=0.
- Overlap: req0 at t, req1 at t+4, req0 drops t+6, req1 drops t+9.
  - ack moves 01→11→10→00 with 1-cycle lag.
  - stall stays 1 continuously; stall_events=1.
- Hold-off and saturation: re-request during RESUME → no drain_req until RUN, then normal 2-cycle entry.
  - With CNT_W=4, 20 stall cycles → stall_cycles=15.
- Reset mid-STALL: reset asserted for 1 cycle → next cycle all outputs 0 and state RUN.
  - With req still high, drain_req=1 one cycle after reset is released.
